// File: rtl/min4_collector_if.sv
// Handshake bundle for min4_collector: sample input, result output and the
// delivered-group counter.
interface min4_collector_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_min;
  logic [1:0]        out_idx;
  logic [7:0]        grp_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_idx, grp_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_idx, grp_cnt
  );
endinterface

// File: rtl/min4_collector.sv
// Collects groups of four samples and reports the unsigned minimum and its
// arrival slot, with valid/ready handshakes on both sides.
module min4_collector #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  min4_collector_if.slave bus
);

  typedef enum logic [1:0] {FILL, CALC, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [3:0][DATA_W-1:0]  slot_q, slot_d;
  logic [DATA_W-1:0]       min_q, min_d;
  logic [1:0]              idx_q, idx_d;
  logic [7:0]              grp_q, grp_d;

  logic                    in_hs, out_hs;
  logic [DATA_W-1:0]       cand_min;
  logic [1:0]              cand_idx;

  assign in_hs  = bus.in_valid  && (state_q == FILL);
  assign out_hs = bus.out_ready && (state_q == HOLD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides every handshake
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (in_hs && cnt_q == 2'd3) state_d = CALC;
        CALC:    state_d = HOLD;
        HOLD:    if (out_hs) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.out_valid = (state_q == HOLD);
  end

  // Strict less-than keeps the earliest slot on ties
  always_comb begin
    cand_min = slot_q[0];
    cand_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (slot_q[i] < cand_min) begin
        cand_min = slot_q[i];
        cand_idx = 2'(i);
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    min_d  = min_q;
    idx_d  = idx_q;
    grp_d  = grp_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else begin
      if (in_hs) begin
        slot_d[cnt_q] = bus.in_data;
        cnt_d         = cnt_q + 2'd1;
      end
      if (state_q == CALC) begin
        min_d = cand_min;
        idx_d = cand_idx;
      end
      if (out_hs) grp_d = grp_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      slot_q <= '0;
      min_q  <= '0;
      idx_q  <= '0;
      grp_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      min_q  <= min_d;
      idx_q  <= idx_d;
      grp_q  <= grp_d;
    end
  end

  assign bus.out_min = min_q;
  assign bus.out_idx = idx_q;
  assign bus.grp_cnt = grp_q;

endmodule

// File: tb/tb_min4_collector.sv
// Directed bench for min4_collector: one task per scenario, inline checks.
module tb_min4_collector;
  localparam int DATA_W = 8;

  logic clk, rst_n, clear;
  int   tests, errs;

  min4_collector_if #(.DATA_W(DATA_W)) bus ();

  min4_collector #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Drive one sample; returns after the accepting edge (+1).
  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t == 20) begin
      tests++; errs++;
      $display("FAIL send_timeout: in_ready stuck at %0b, want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_min, bus.out_idx, bus.grp_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0, 8'h00}) begin
      errs++;
      $display("FAIL reset_state: rdy=%0b vld=%0b min=%h idx=%0d grp=%0d, want 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.out_min, bus.out_idx, bus.grp_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send4(8'hA0, 8'hA1, 8'hA2, 8'hB3);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL basic_calc: vld=%0b rdy=%0b, want 0 0", bus.out_valid, bus.in_ready);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 8'hA0 || bus.out_idx !== 2'd0 || bus.grp_cnt !== 8'd0) begin
      errs++;
      $display("FAIL basic_result: vld=%0b min=%h idx=%0d grp=%0d, want 1 a0 0 0",
               bus.out_valid, bus.out_min, bus.out_idx, bus.grp_cnt);
    end
    step();
    tests++;
    if (bus.grp_cnt !== 8'd1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL basic_handshake: grp=%0d vld=%0b rdy=%0b, want 1 0 1",
               bus.grp_cnt, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_min_last_tie();
    send4(8'hB4, 8'hA5, 8'hB6, 8'hB7);
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 8'hA5 || bus.out_idx !== 2'd1) begin
      errs++;
      $display("FAIL tie_grp1: vld=%0b min=%h idx=%0d, want 1 a5 1", bus.out_valid, bus.out_min, bus.out_idx);
    end
    step();
    send4(8'hA8, 8'hA9, 8'hBA, 8'hA8);
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 8'hA8 || bus.out_idx !== 2'd0) begin
      errs++;
      $display("FAIL tie_grp2: vld=%0b min=%h idx=%0d, want 1 a8 0", bus.out_valid, bus.out_min, bus.out_idx);
    end
    step();
    tests++;
    if (bus.grp_cnt !== 8'd3) begin
      errs++;
      $display("FAIL tie_grp_cnt: grp=%0d, want 3", bus.grp_cnt);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send4(8'h10, 8'h05, 8'h05, 8'h20);
    step();
    // Offer a would-be new minimum while stalled; it must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_min !== 8'h05 || bus.out_idx !== 2'd1 ||
          bus.in_ready !== 1'b0 || bus.grp_cnt !== 8'd3) begin
        errs++;
        $display("FAIL bp_hold[%0d]: vld=%0b min=%h idx=%0d rdy=%0b grp=%0d, want 1 05 1 0 3",
                 i, bus.out_valid, bus.out_min, bus.out_idx, bus.in_ready, bus.grp_cnt);
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    tests++;
    if (bus.grp_cnt !== 8'd4 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_release: grp=%0d rdy=%0b vld=%0b, want 4 1 0", bus.grp_cnt, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_clear();
    send(8'h01);
    send(8'h02);
    clear = 1'b1;
    step();
    clear = 1'b0;
    send4(8'h30, 8'h20, 8'h40, 8'h50);
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 8'h20 || bus.out_idx !== 2'd1) begin
      errs++;
      $display("FAIL clear_fill: vld=%0b min=%h idx=%0d, want 1 20 1", bus.out_valid, bus.out_min, bus.out_idx);
    end
    step();
    tests++;
    if (bus.grp_cnt !== 8'd5) begin
      errs++;
      $display("FAIL clear_fill_cnt: grp=%0d, want 5", bus.grp_cnt);
    end
    bus.out_ready = 1'b0;
    send4(8'h60, 8'h61, 8'h62, 8'h63);
    step();
    clear         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.grp_cnt !== 8'd5 || bus.in_ready !== 1'b1 ||
        bus.out_min !== 8'h60 || bus.out_idx !== 2'd0) begin
      errs++;
      $display("FAIL clear_hold: vld=%0b grp=%0d rdy=%0b min=%h idx=%0d, want 0 5 1 60 0",
               bus.out_valid, bus.grp_cnt, bus.in_ready, bus.out_min, bus.out_idx);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send4(8'h70, 8'h71, 8'h72, 8'h73);
    step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_min, bus.out_idx, bus.grp_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0, 8'h00}) begin
      errs++;
      $display("FAIL async_reset: rdy=%0b vld=%0b min=%h idx=%0d grp=%0d, want 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.out_min, bus.out_idx, bus.grp_cnt);
    end
    #1 rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    send4(8'h09, 8'h0A, 8'h0B, 8'h0C);
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_min !== 8'h09 || bus.out_idx !== 2'd0) begin
      errs++;
      $display("FAIL post_reset_grp: vld=%0b min=%h idx=%0d, want 1 09 0", bus.out_valid, bus.out_min, bus.out_idx);
    end
    step();
    tests++;
    if (bus.grp_cnt !== 8'd1) begin
      errs++;
      $display("FAIL post_reset_cnt: grp=%0d, want 1", bus.grp_cnt);
    end
  endtask

  task automatic test_wrap();
    for (int g = 0; g < 254; g++) begin
      send4(8'(g), 8'h80, 8'h81, 8'h82);
      step(); step();
    end
    tests++;
    if (bus.grp_cnt !== 8'd255) begin
      errs++;
      $display("FAIL wrap_255: grp=%0d, want 255", bus.grp_cnt);
    end
    send4(8'hFF, 8'hFE, 8'hFD, 8'hFC);
    step();
    tests++;
    if (bus.out_min !== 8'hFC || bus.out_idx !== 2'd3) begin
      errs++;
      $display("FAIL wrap_last_min: min=%h idx=%0d, want fc 3", bus.out_min, bus.out_idx);
    end
    step();
    tests++;
    if (bus.grp_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL wrap_0: grp=%0d rdy=%0b, want 0 1", bus.grp_cnt, bus.in_ready);
    end
  endtask

  initial begin
    tests         = 0;
    errs          = 0;
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_min_last_tie();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/min4_collector.md
MIN4_COLLECTOR -- requirements
Module: min4_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the sample width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port clear, input, 1, synchronous flush of the group in progress.
REQ-005 SHALL have port in_valid, input, 1, upstream sample valid.
REQ-006 SHALL have port in_data, input, DATA_W, upstream sample.
REQ-007 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-008 SHALL have port out_valid, output, 1, group result valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port out_min, output, DATA_W, unsigned minimum of the 4-sample group.
REQ-011 SHALL have port out_idx, output, 2, arrival position (0..3) of the minimum.
REQ-012 SHALL have port grp_cnt, output, 8, count of results delivered.

Function
REQ-013 SHALL accept a sample only on a rising edge where in_valid=1 and in_ready=1 (input handshake).
REQ-014 SHALL store accepted samples in arrival order in slots 0..3 and hold a 2-bit fill count.
REQ-015 SHALL implement FSM states FILL, CALC and HOLD.
REQ-016 SHALL drive in_ready=1 only in FILL; in CALC and HOLD in_ready=0.
REQ-017 In FILL, SHALL move to CALC on the handshake that accepts the 4th sample (count 3->0).
REQ-018 In CALC, SHALL spend exactly one cycle, register out_min/out_idx, then move to HOLD.
REQ-019 In HOLD, SHALL drive out_valid=1 and keep out_min/out_idx stable until the output handshake.
REQ-020 On an output handshake (out_valid=1 and out_ready=1 at an edge), SHALL increment grp_cnt and move to FILL.
REQ-021 Latency: if the 4th sample is accepted at edge E, out_valid SHALL be 1 after edge E+1.
REQ-022 Compare SHALL be unsigned over the full DATA_W.
REQ-023 On equal minima, out_idx SHALL select the lowest index (the earliest arrival).
REQ-024 grp_cnt SHALL wrap from 255 to 0 with no flag.
REQ-025 out_valid SHALL NOT be asserted in FILL or CALC.
REQ-026 out_min/out_idx SHALL hold their last values outside HOLD.
REQ-027 When clear=1 at an edge, SHALL go to FILL with count=0 and out_valid=0.
- This applies in any state, including a pending HOLD result, which is discarded.
- grp_cnt is unchanged, and in_data is not captured that cycle.
REQ-028 clear SHALL take priority over a simultaneous input or output handshake.
REQ-029 out_ready while not in HOLD SHALL be ignored.
REQ-030 in_valid while in_ready=0 SHALL be ignored; upstream holds the data.

Reset
REQ-031 While rst_n=0, SHALL force the following immediately, without waiting for clk:
- state=FILL, count=0, in_ready=1, out_valid=0;
- out_min=0, out_idx=0, grp_cnt=0, all sample slots=0.
REQ-032 Reset asserted mid-group or in HOLD SHALL discard all partial and pending data.
REQ-033 After rst_n deasserts, the first accepted sample SHALL go to slot 0.

Verification
REQ-034 Basic: samples 0xA0,0xA1,0xA2,0xB3 with out_ready=1 -> one cycle after the 4th accept, out_valid=1, out_min=0xA0, out_idx=0; next edge grp_cnt=1.
REQ-035 Min last, with tie: samples 0xB4,0xA5,0xB6,0xB7, then 0xA8,0xA9,0xBA,0xA8 -> results (0xA5,1), then (0xA8,0).
REQ-036 Backpressure: group 0x10,0x05,0x05,0x20 with out_ready=0 for 5 cycles -> response:
- out_valid=1, out_min=0x05, out_idx=1, held stable throughout;
- in_ready=0 throughout and grp_cnt unchanged;
- when out_ready=1 -> one handshake, then in_ready=1.
REQ-037 Clear mid-fill and in HOLD:
- 2 samples, clear, then 0x30,0x20,0x40,0x50 -> out_min=0x20, out_idx=1.
- clear while in HOLD -> out_valid drops and grp_cnt is not incremented.
REQ-038 Async reset: drop rst_n between clock edges while in HOLD -> outputs take reset values before the next clk edge; a new 4-sample group then yields grp_cnt=1.
REQ-039 Wrap: deliver 256 groups -> grp_cnt reads 0 after the 256th output handshake.
